// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_if
//  Description : Writeback bus between the two writeback requesters (ALU path
//                and load path), the write-port arbiter and the register file.
//                - req0_* / req1_* : valid/ready request channels
//                - wr_*            : registered register-file write port
//                - init_done       : init sweep has completed
//                - last_grant      : requester granted most recently
//                master modport = requester/observer side
//                slave modport  = arbiter side
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int BITSIZE = 64,
  parameter int REGSIZE = 32
);
  localparam int SW = $clog2(REGSIZE);

  logic               req0_valid;
  logic [SW-1:0]      req0_sel;
  logic [BITSIZE-1:0] req0_data;
  logic               req0_ready;

  logic               req1_valid;
  logic [SW-1:0]      req1_sel;
  logic [BITSIZE-1:0] req1_data;
  logic               req1_ready;

  logic [SW-1:0]      wr_sel;
  logic [BITSIZE-1:0] wr_data;
  logic               wr_en;
  logic               init_done;
  logic               last_grant;

  modport master (
    output req0_valid, req0_sel, req0_data,
    input  req0_ready,
    output req1_valid, req1_sel, req1_data,
    input  req1_ready,
    input  wr_sel, wr_data, wr_en, init_done, last_grant
  );

  modport slave (
    input  req0_valid, req0_sel, req0_data,
    output req0_ready,
    input  req1_valid, req1_sel, req1_data,
    output req1_ready,
    output wr_sel, wr_data, wr_en, init_done, last_grant
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Owns the single write port of the register file.
//                After reset it sweeps registers 0..ZERO_REG-1, loading each
//                with its own index. It then round-robin arbitrates the ALU
//                (req0) and load (req1) writeback requesters onto the port.
//  Ports       : clk   - clock, all state on the rising edge
//                rst_n - asynchronous active-low reset
//                bus   - slave side of regfile_wb_arbiter_if
//                        (request channels, write port, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int BITSIZE  = 64,
  parameter int REGSIZE  = 32,
  parameter int ZERO_REG = REGSIZE - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int            SW       = $clog2(REGSIZE);
  localparam logic [SW-1:0] ZERO_SEL = SW'(ZERO_REG);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q;
  logic [SW-1:0]      cnt_q;
  logic [SW-1:0]      wr_sel_q;
  logic [BITSIZE-1:0] wr_data_q;
  logic               wr_en_q;
  logic               init_done_q;
  logic               last_grant_q;

  logic               grant_vld_d;
  logic               grant_d;
  logic [SW-1:0]      win_sel_d;
  logic [BITSIZE-1:0] win_data_d;

  // Same-cycle grant. With both requesters valid the one that did not win
  // last time gets the port, which alternates them under contention.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_d     = 1'b0;
    if (state_q == ST_RUN) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_vld_d = 1'b1;
        grant_d     = ~last_grant_q;
      end else if (bus.req0_valid) begin
        grant_vld_d = 1'b1;
        grant_d     = 1'b0;
      end else if (bus.req1_valid) begin
        grant_vld_d = 1'b1;
        grant_d     = 1'b1;
      end
    end
    win_sel_d  = grant_d ? bus.req1_sel  : bus.req0_sel;
    win_data_d = grant_d ? bus.req1_data : bus.req0_data;
  end

  assign bus.req0_ready = grant_vld_d & ~grant_d;
  assign bus.req1_ready = grant_vld_d &  grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      wr_sel_q     <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      init_done_q  <= 1'b0;
      last_grant_q <= 1'b1;   // requester 0 wins the first contention
    end else begin
      case (state_q)
        ST_INIT: begin
          // cnt reaching ZERO_SEL means the last sweep write is already on
          // the port; this edge retires the sweep without writing ZERO_REG.
          if (cnt_q == ZERO_SEL) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
            wr_en_q     <= 1'b0;
          end else begin
            wr_en_q   <= 1'b1;
            wr_sel_q  <= cnt_q;
            wr_data_q <= BITSIZE'(cnt_q);
            cnt_q     <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (grant_vld_d) begin
            // A write to the zero register is accepted but dropped.
            wr_sel_q     <= win_sel_d;
            wr_data_q    <= win_data_d;
            wr_en_q      <= (win_sel_d != ZERO_SEL);
            last_grant_q <= grant_d;
          end else begin
            wr_en_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.wr_sel     = wr_sel_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.init_done  = init_done_q;
  assign bus.last_grant = last_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter. A cycle-level
//                reference model predicts readies and write-port contents;
//                a behavioural register file records what the port commits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int ZR = 31;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.BITSIZE(64), .REGSIZE(32)) bus ();

  regfile_wb_arbiter #(.BITSIZE(64), .REGSIZE(32), .ZERO_REG(ZR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file as seen through the write port (no hardwired zero here,
  // so a stray write to register 31 is visible).
  logic [63:0] obs  [32] = '{default: '0};
  // What the register file should contain according to the model.
  logic [63:0] gold [32] = '{default: '0};

  always @(posedge clk) begin
    if (bus.wr_en) obs[bus.wr_sel] <= bus.wr_data;
  end

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model state
  int          m_cyc;      // rising edges since reset release
  logic        m_last;
  logic        m_en;
  logic [4:0]  m_sel;
  logic [63:0] m_data;
  logic        m_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_cyc = 0; m_last = 1'b1; m_en = 1'b0; m_sel = '0; m_data = '0; m_done = 1'b0;
  endtask

  // One clock cycle: check readies for the inputs currently driven, take
  // the edge, advance the model, check the registered outputs.
  task automatic step(output bit er0, output bit er1);
    logic [4:0]  s0, s1, ws;
    logic [63:0] d0, d1, wd;
    #1;
    er0 = 1'b0; er1 = 1'b0;
    if (m_cyc > ZR) begin
      if (bus.req0_valid && bus.req1_valid) begin
        er0 = m_last; er1 = !m_last;
      end else begin
        er0 = bus.req0_valid; er1 = bus.req1_valid;
      end
    end
    chk("req0_ready", 64'(bus.req0_ready), 64'(er0));
    chk("req1_ready", 64'(bus.req1_ready), 64'(er1));
    s0 = bus.req0_sel; d0 = bus.req0_data;
    s1 = bus.req1_sel; d1 = bus.req1_data;
    @(posedge clk);
    m_cyc++;
    if (m_cyc <= ZR) begin
      m_en = 1'b1; m_sel = 5'(m_cyc - 1); m_data = 64'(m_cyc - 1);
      gold[m_cyc - 1] = 64'(m_cyc - 1);
    end else if (m_cyc == ZR + 1) begin
      m_en = 1'b0; m_done = 1'b1;
    end else if (er0 || er1) begin
      ws = er1 ? s1 : s0;
      wd = er1 ? d1 : d0;
      m_sel = ws; m_data = wd; m_en = (ws != 5'(ZR)); m_last = er1;
      if (ws != 5'(ZR)) gold[ws] = wd;
    end else begin
      m_en = 1'b0;
    end
    #1;
    chk("wr_en",      64'(bus.wr_en),      64'(m_en));
    chk("wr_sel",     64'(bus.wr_sel),     64'(m_sel));
    chk("wr_data",    bus.wr_data,         m_data);
    chk("init_done",  64'(bus.init_done),  64'(m_done));
    chk("last_grant", 64'(bus.last_grant), 64'(m_last));
  endtask

  typedef struct {
    logic        v0; logic [4:0] s0; logic [63:0] d0;
    logic        v1; logic [4:0] s1; logic [63:0] d1;
    logic        r0; logic r1;
    logic        en; logic [4:0] sel; logic [63:0] data; logic last;
  } vec_t;

  vec_t vt [10];

  initial begin
    bit er0, er1, p0, p1;
    logic [63:0] a, b;
    a = 64'hAAAA_AAAA_AAAA_AAAA;
    b = 64'hBBBB_BBBB_BBBB_BBBB;
    // Starting from last_grant=1 right after the sweep.
    vt[0] = '{1'b1, 5'd1, a, 1'b1, 5'd2, b, 1'b1, 1'b0, 1'b1, 5'd1, a, 1'b0};
    vt[1] = '{1'b1, 5'd1, a, 1'b1, 5'd2, b, 1'b0, 1'b1, 1'b1, 5'd2, b, 1'b1};
    vt[2] = '{1'b1, 5'd1, a, 1'b1, 5'd2, b, 1'b1, 1'b0, 1'b1, 5'd1, a, 1'b0};
    vt[3] = '{1'b1, 5'd1, a, 1'b1, 5'd2, b, 1'b0, 1'b1, 1'b1, 5'd2, b, 1'b1};
    vt[4] = '{1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0};
    vt[5] = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hFFFF, 1'b0, 1'b1, 1'b0, 5'd31, 64'hFFFF, 1'b1};
    vt[6] = '{1'b1, 5'd3, 64'd3, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1'b1, 5'd3, 64'd3, 1'b0};
    vt[7] = '{1'b1, 5'd7, 64'd1, 1'b1, 5'd7, 64'd2, 1'b0, 1'b1, 1'b1, 5'd7, 64'd2, 1'b1};
    vt[8] = '{1'b1, 5'd7, 64'd1, 1'b0, 5'd7, 64'd2, 1'b1, 1'b0, 1'b1, 5'd7, 64'd1, 1'b0};
    vt[9] = '{1'b0, 5'd7, 64'd1, 1'b0, 5'd7, 64'd2, 1'b0, 1'b0, 1'b0, 5'd7, 64'd1, 1'b0};

    bus.req0_valid = 1'b0; bus.req0_sel = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_sel = '0; bus.req1_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst wr_en",      64'(bus.wr_en),      64'd0);
    chk("rst wr_sel",     64'(bus.wr_sel),     64'd0);
    chk("rst wr_data",    bus.wr_data,         64'd0);
    chk("rst init_done",  64'(bus.init_done),  64'd0);
    chk("rst last_grant", 64'(bus.last_grant), 64'd1);
    rst_n = 1'b1;
    model_reset();

    // Partial sweep with req0 pending, aborted at index 12
    bus.req0_valid = 1'b1; bus.req0_sel = 5'd9; bus.req0_data = 64'h123;
    while (m_cyc < 13) step(er0, er1);
    chk("pre-abort wr_sel", 64'(bus.wr_sel), 64'd12);
    rst_n = 1'b0;
    #1;
    chk("async wr_en",      64'(bus.wr_en),      64'd0);
    chk("async wr_sel",     64'(bus.wr_sel),     64'd0);
    chk("async wr_data",    bus.wr_data,         64'd0);
    chk("async init_done",  64'(bus.init_done),  64'd0);
    chk("async last_grant", 64'(bus.last_grant), 64'd1);
    chk("async req0_ready", 64'(bus.req0_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Full sweep; req0 held valid but never accepted
    while (m_cyc < ZR) step(er0, er1);
    bus.req0_valid = 1'b0;
    step(er0, er1);
    chk("sweep done init_done", 64'(bus.init_done), 64'd1);
    chk("sweep done wr_en",     64'(bus.wr_en),     64'd0);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      bus.req0_valid = vt[i].v0; bus.req0_sel = vt[i].s0; bus.req0_data = vt[i].d0;
      bus.req1_valid = vt[i].v1; bus.req1_sel = vt[i].s1; bus.req1_data = vt[i].d1;
      #1;
      chk($sformatf("vec%0d req0_ready", i), 64'(bus.req0_ready), 64'(vt[i].r0));
      chk($sformatf("vec%0d req1_ready", i), 64'(bus.req1_ready), 64'(vt[i].r1));
      step(er0, er1);
      chk($sformatf("vec%0d wr_en", i),      64'(bus.wr_en),      64'(vt[i].en));
      chk($sformatf("vec%0d wr_sel", i),     64'(bus.wr_sel),     64'(vt[i].sel));
      chk($sformatf("vec%0d wr_data", i),    bus.wr_data,         vt[i].data);
      chk($sformatf("vec%0d last_grant", i), 64'(bus.last_grant), 64'(vt[i].last));
    end
    chk("reg7 last writer", obs[7],  64'd1);
    chk("reg31 untouched",  obs[31], 64'd0);
    chk("reg5 written",     obs[5],  64'hDEAD_BEEF);
    chk("reg12 from sweep", obs[12], 64'd12);

    // Randomized traffic; requesters hold until accepted
    p0 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1;
        bus.req0_sel  = 5'($urandom_range(0, 31));
        bus.req0_data = {$urandom(), $urandom()};
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1;
        bus.req1_sel  = 5'($urandom_range(0, 31));
        bus.req1_data = {$urandom(), $urandom()};
      end
      bus.req0_valid = p0;
      bus.req1_valid = p1;
      step(er0, er1);
      if (er0) p0 = 1'b0;
      if (er1) p1 = 1'b0;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) step(er0, er1);
    for (int r = 0; r < 32; r++) chk($sformatf("regfile[%0d]", r), obs[r], gold[r]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequences and shares the single write port of the 64-bit, 32-entry register file.
- After reset it runs an init sweep that loads every register except the zero register with its own index. This reproduces the file's power-up contents under controller control.
- In normal operation it round-robin arbitrates two writeback requesters (ALU path, load path) onto the port using valid/ready handshakes.
- Write outputs are registered and drive the register file's select, data and enable inputs directly.

Parameters:
BITSIZE, 64, data width of a register
REGSIZE, 32, number of registers; select width SW = $clog2(REGSIZE)
ZERO_REG, REGSIZE-1, hardwired-zero register index; writes to it are never issued

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 (ALU) has a write
req0_sel  input  SW  requester 0 destination register
req0_data  input  BITSIZE  requester 0 write data
req0_ready  output  1  requester 0 write accepted this cycle
req1_valid  input  1  requester 1 (load) has a write
req1_sel  input  SW  requester 1 destination register
req1_data  input  BITSIZE  requester 1 write data
req1_ready  output  1  requester 1 write accepted this cycle
wr_sel  output  SW  register file write select
wr_data  output  BITSIZE  register file write data
wr_en  output  1  register file write enable
init_done  output  1  high once the init sweep has completed
last_grant  output  1  requester granted most recently (0 or 1)

Behaviour:
- Reset (rst low, asynchronous):
  - state=INIT, init counter=0, wr_en=0, wr_sel=0, wr_data=0.
  - init_done=0, last_grant=1, so requester 0 wins first.
  - Reset asserted mid-sweep or mid-RUN aborts everything; the sweep restarts from 0 after release.
- FSM: INIT -> RUN. RUN is terminal until the next reset.
- INIT:
  - Each cycle, register wr_en=1, wr_sel=cnt, wr_data=cnt zero-extended to BITSIZE, then cnt++.
  - After issuing cnt=ZERO_REG-1, go to RUN on the next edge.
  - Count: exactly ZERO_REG write cycles (31 with defaults). ZERO_REG is never written.
  - req0_ready=req1_ready=0 throughout. Requesters must hold valid/sel/data stable until accepted.
- RUN:
  - init_done=1 from the first RUN cycle.
  - Grant (combinational, same cycle):
    - Only one valid: that requester is granted.
    - Both valid: grant goes to the requester that is not last_grant.
    - reqN_ready = grant to N. At most one ready is high per cycle. Ready never rises without the matching valid.
  - On a handshake (valid&ready), next edge:
    - wr_sel and wr_data take the winner's sel and data.
    - wr_en=1, except wr_en=0 when sel==ZERO_REG.
    - last_grant = winner.
  - The handshake still completes for a ZERO_REG write: ready is high, the write is consumed and silently dropped, and last_grant updates.
  - No handshake: wr_en=0 next edge; wr_sel/wr_data hold their previous values; last_grant holds.
- Latency: acceptance in cycle N gives the write on the port in cycle N+1; the register file commits it at edge N+2.
  - Throughput: one write per cycle, back-to-back.
- Same destination from both requesters in one cycle: only the winner is written. The loser stays pending and writes next cycle (last writer wins).
- Unused select values (>=REGSIZE when REGSIZE is not a power of 2): passed through unchanged. Range checking is not this block's responsibility.

Test Plan:
- Release rst, no requests -> 31 cycles with wr_en=1 and wr_sel=wr_data=0..30 in order; the register file reads regN==N and reg31==0; init_done rises in cycle 32; readies stay 0 during the sweep even with req0_valid held high.
- RUN, req0 only: sel=5, data=64'hDEAD_BEEF -> req0_ready=1 the same cycle; next cycle wr_en=1, wr_sel=5, wr_data=64'hDEAD_BEEF; last_grant=0.
- Both valid for 4 cycles: req0 sel=1 data=A, req1 sel=2 data=B -> grants 0,1,0,1 (req0 first after reset); wr_sel sequence 1,2,1,2; exactly one ready per cycle.
- req1 writes sel=31, data=64'hFFFF -> req1_ready=1, next cycle wr_en=0, reg31 still reads 0, last_grant=1.
- Both target sel=7 (req0 data=1, req1 data=2, last_grant=0) -> req1 wins first (reg7=2), then req0 next cycle (reg7=1).
- Pull rst low at sweep index 12 for 1 cycle -> outputs clear immediately (asynchronously); after release the sweep restarts at wr_sel=0; init_done stays 0 until the full 31-cycle sweep finishes.
